// File: rtl/muldiv_sequencer.sv
// Sequential 32x32 multiply / restoring divide unit with HI/LO result registers.
// Optional divide support is enabled by defining MULDIV_DIVIDE_EN.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    output logic        busy,
    output logic        stall_pipeline,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_error
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN_FIX, DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_p;
    logic [31:0] r_b;
    logic        r_sa;
    logic        r_sb;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_sum;
    logic [63:0] w_mul_next;
    logic [63:0] w_step;
    logic [63:0] w_prod_neg;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;
    logic        w_accept;
    logic        w_bad;

    assign w_a_neg = ~op[0] & operand_a[31];
    assign w_b_neg = ~op[0] & operand_b[31];
    assign w_a_mag = w_a_neg ? -operand_a : operand_a;
    assign w_b_mag = w_b_neg ? -operand_b : operand_b;

    // Shift-add: low half holds the unconsumed multiplier bits.
    assign w_sum = r_p[0] ? ({1'b0, r_p[63:32]} + {1'b0, r_b})
                          : {1'b0, r_p[63:32]};
    assign w_mul_next = {w_sum, r_p[31:1]};
    assign w_prod_neg = -r_p;

    assign w_accept = start & ~flush;

`ifdef MULDIV_DIVIDE_EN
    logic        r_div;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [63:0] w_div_next;

    // Restoring step: remainder in upper half, quotient shifts into lower half.
    assign w_rem_sh   = {r_p[63:32], r_p[31]};
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_div_next = w_diff[32] ? {w_rem_sh[31:0], r_p[30:0], 1'b0}
                                   : {w_diff[31:0], r_p[30:0], 1'b1};
    assign w_step     = r_div ? w_div_next : w_mul_next;
    assign w_bad      = op[1] & (operand_b == 32'd0);

    always_comb begin
        w_fix_hi = r_p[63:32];
        w_fix_lo = r_p[31:0];
        if (r_div) begin
            if (r_sa ^ r_sb) w_fix_lo = -r_p[31:0];
            if (r_sa)        w_fix_hi = -r_p[63:32];
        end else if (r_sa ^ r_sb) begin
            w_fix_hi = w_prod_neg[63:32];
            w_fix_lo = w_prod_neg[31:0];
        end
    end
`else
    assign w_step = w_mul_next;
    assign w_bad  = op[1];

    always_comb begin
        w_fix_hi = r_p[63:32];
        w_fix_lo = r_p[31:0];
        if (r_sa ^ r_sb) begin
            w_fix_hi = w_prod_neg[63:32];
            w_fix_lo = w_prod_neg[31:0];
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
            r_p     <= 64'd0;
            r_b     <= 32'd0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            r_div   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (w_accept) begin
                        if (w_bad) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
`ifdef MULDIV_DIVIDE_EN
                            r_hi    <= operand_a;
                            r_lo    <= 32'hFFFF_FFFF;
`endif
                        end else begin
                            r_state <= CALC;
                            r_busy  <= 1'b1;
                            r_cnt   <= 5'd0;
                            r_p     <= {32'd0, w_a_mag};
                            r_b     <= w_b_mag;
                            r_sa    <= w_a_neg;
                            r_sb    <= w_b_neg;
`ifdef MULDIV_DIVIDE_EN
                            r_div   <= op[1];
`endif
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_p   <= w_step;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) r_state <= SIGN_FIX;
                    end
                end
                SIGN_FIX: begin
                    r_busy <= 1'b0;
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        r_hi    <= w_fix_hi;
                        r_lo    <= w_fix_lo;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign div_error      = r_err;
    assign hi             = r_hi;
    assign lo             = r_lo;
    assign stall_pipeline = r_busy | (start & (r_state == IDLE) & ~flush);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver queues expected results,
// a negedge monitor checks every done pulse against the queue head.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall_pipeline;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_error;

    muldiv_sequencer dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .flush(flush),
        .busy(busy),
        .stall_pipeline(stall_pipeline),
        .done(done),
        .hi(hi),
        .lo(lo),
        .div_error(div_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        eerr;
        int          ecyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_hi = 32'd0;
    logic [31:0] prev_lo = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"}, 64'(hi), 64'(e.ehi));
                chk({e.name, "_lo"}, 64'(lo), 64'(e.elo));
                chk({e.name, "_err"}, 64'(div_error), 64'(e.eerr));
                chk({e.name, "_cycle"}, 64'(cyc), 64'(e.ecyc));
            end
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int t0);
        @(negedge clk);
        start = 1'b1;
        op = o;
        operand_a = a;
        operand_b = b;
        #1;
        chk("stall_on_start", 64'(stall_pipeline), 64'd1);
        t0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input string name, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic eerr, input int lat, input logic fl_done);
        int t0;
        int scnt;
        bit seen;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op = o;
        operand_a = a;
        operand_b = b;
        #1;
        chk({name, "_stall_T"}, 64'(stall_pipeline), 64'd1);
        t0 = cyc;
        e.ehi = ehi;
        e.elo = elo;
        e.eerr = eerr;
        e.ecyc = t0 + lat;
        e.name = name;
        sb.push_back(e);
        prev_hi = ehi;
        prev_lo = elo;
        @(posedge clk);
        #1 start = 1'b0;
        scnt = 0;
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (stall_pipeline) scnt++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
        end
        chk({name, "_stall_cycles"}, 64'(scnt), 64'(lat - 1));
        if (fl_done) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk({name, "_after_busy"}, 64'(busy), 64'd0);
        chk({name, "_after_hilo"}, {hi, lo}, {ehi, elo});
    endtask

    task automatic run_div(input string name, input logic [1:0] o,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo,
                           input logic eerr, input int lat);
`ifdef MULDIV_DIVIDE_EN
        run(name, o, a, b, ehi, elo, eerr, lat, 1'b0);
`else
        run(name, o, a, b, prev_hi, prev_lo, 1'b1, 1, 1'b0);
`endif
    endtask

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(div_error), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_stall", 64'(stall_pipeline), 64'd0);

        run("multu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 1'b0);
        run("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b0);

        // Flush mid-CALC, then restart immediately.
        launch(2'b01, 32'd5, 32'd6, t0);
        while (cyc < t0 + 10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hilo", {hi, lo}, {prev_hi, prev_lo});
        run("multu_5x6", 2'b01, 32'd5, 32'd6,
            32'd0, 32'h0000_001E, 1'b0, 34, 1'b0);

        run("mult_m1xm1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'd0, 32'd1, 1'b0, 34, 1'b0);
        run("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000,
            32'h4000_0000, 32'd0, 1'b0, 34, 1'b0);

        run_div("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        run_div("divu_100_7", 2'b11, 32'd100, 32'd7,
                32'd2, 32'd14, 1'b0, 34);
        run_div("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE,
                32'd1, 32'hFFFF_FFFD, 1'b0, 34);
        run_div("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                32'd0, 32'h8000_0000, 1'b0, 34);
`ifdef MULDIV_DIVIDE_EN
        run("divu_by0", 2'b11, 32'd100, 32'd0,
            32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1, 1'b1);
`else
        run("divu_by0", 2'b11, 32'd100, 32'd0,
            prev_hi, prev_lo, 1'b1, 1, 1'b1);
`endif

        // Flush and start together in IDLE: nothing starts.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op = 2'b01;
        operand_a = 32'd9;
        operand_b = 32'd9;
        #1;
        chk("flush_start_stall", 64'(stall_pipeline), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-operation.
        launch(2'b00, 32'd1234, 32'd5678, t0);
        while (cyc < t0 + 5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        repeat (40) @(negedge clk);
        chk("midrst_hold", {hi, lo}, 64'd0);

        run("post_rst", 2'b01, 32'd5, 32'd6,
            32'd0, 32'h0000_001E, 1'b0, 34, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
REQ-005 SHALL have port operand_a  input  32  multiplicand or dividend; sampled with start.
REQ-006 SHALL have port operand_b  input  32  multiplier or divisor; sampled with start.
REQ-007 SHALL have port flush  input  1  abort the in-flight operation.
REQ-008 SHALL have port busy  output  1  high in CALC and SIGN_FIX.
REQ-009 SHALL have port stall_pipeline  output  1  combinational: busy OR (start AND state==IDLE AND NOT flush).
REQ-010 SHALL have port done  output  1  one-cycle pulse while state==DONE.
REQ-011 SHALL have port hi  output  32  HI register (product[63:32] or remainder).
REQ-012 SHALL have port lo  output  32  LO register (product[31:0] or quotient).
REQ-013 SHALL have port div_error  output  1  high with done when the divisor is zero or the op is unsupported.

Function
REQ-014 SHALL implement states IDLE, CALC, SIGN_FIX, DONE; DONE SHALL return to IDLE after one cycle unconditionally.
REQ-015 start in IDLE at edge T SHALL latch operand magnitudes (absolute values for signed ops), the result-sign flags and op; the next state SHALL be CALC.
REQ-016 CALC SHALL run exactly 32 cycles (T+1..T+32) under a 5-bit iteration counter, one shift-add (multiply) or one restoring subtract-shift (divide) per cycle.
REQ-017 SIGN_FIX at T+33 SHALL negate the product if sign(a) XOR sign(b) for mult, negate the quotient if signs differ for div, and give the remainder the sign of the dividend; unsigned ops pass through unchanged.
REQ-018 hi/lo SHALL update only on the edge entering DONE; done SHALL be high for cycle T+34, and the result SHALL be visible on hi/lo in that cycle.
REQ-019 Divide by zero (op 1x, operand_b==0) SHALL skip CALC: DONE at T+1, hi=operand_a, lo=32'hFFFFFFFF, div_error=1.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=32'h80000000, hi=0, div_error=0.
REQ-021 start while busy or in DONE SHALL be ignored; requesters SHALL hold start until stall_pipeline drops.
REQ-022 flush in CALC or SIGN_FIX SHALL return to IDLE on the next edge with no done pulse and hi/lo unchanged.
REQ-023 flush and start together in IDLE SHALL take flush: the operation SHALL not start and stall_pipeline SHALL be 0.
REQ-024 flush in DONE SHALL have no effect; the result commits.
REQ-025 hi/lo SHALL hold their last committed value while in IDLE.

Reset
REQ-026 reset SHALL force IDLE, counter=0, busy=0, done=0, div_error=0, hi=0, lo=0 immediately, including mid-operation.
REQ-027 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-028 With MULDIV_DIVIDE_EN defined, div/divu SHALL behave as specified above.
REQ-029 Without MULDIV_DIVIDE_EN, divide logic SHALL be absent, and op 10/11 SHALL go to DONE at T+1 with div_error=1 and hi/lo unchanged; mult/multu timing SHALL be unaffected.

Verification
REQ-030 multu 0xFFFFFFFF x 0xFFFFFFFF, start at T -> done at T+34, hi=0xFFFFFFFE, lo=0x00000001, stall_pipeline high T..T+33.
REQ-031 mult 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_error=0.
REQ-032 div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at T+34.
REQ-033 divu 100 / 0 -> done at T+1, hi=0x00000064, lo=0xFFFFFFFF, div_error=1; without MULDIV_DIVIDE_EN the same op -> div_error=1 with hi/lo unchanged.
REQ-034 multu 5x6 started at T, flush at T+10 -> no done, hi/lo keep prior values; start at T+11 with multu 5x6 -> lo=0x0000001E at T+45.
REQ-035 reset pulsed at T+5 of a mult -> busy=0, hi=lo=0 asynchronously; no done follows.
